pc_target_lut_rw: RTL and testbench
===================================

Name: pc_target_lut_rw

Overview:
- Next-generation branch-target lookup table for the fetch stage.
- Depth and target width are parametrised. Entries are written at run time by the program loader instead of being fixed at elaboration.
- Lookup output is registered and qualified by a valid pulse, and can return either the absolute target or a PC-relative target.
- An internal sequencer clears every entry after reset before lookups are accepted.

Parameters:
- D, 10, target / PC width in bits
- A, 4, address width; table depth = 2**A entries

Ports:
- Clk  input  1  single system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- lookup_en  input  1  lookup request, sampled on rising Clk
- addr  input  A  lookup entry index
- rel  input  1  1 = PC-relative result, 0 = absolute entry value
- pc  input  D  current PC, used only when rel=1
- wr_en  input  1  table write strobe
- wr_addr  input  A  write entry index
- wr_data  input  D  value to store (offset in two's complement when used relatively)
- ready  output  1  high once initialisation is complete
- target  output  D  registered lookup result
- target_valid  output  1  one-cycle pulse qualifying target

Behaviour:
- Reset asserted, asynchronously:
  - ready=0, target=0, target_valid=0
  - state=INIT, init counter=0
  - table contents are don't-care until INIT completes
- State INIT:
  - each cycle writes 0 to entry[cnt], then cnt increments
  - after writing entry 2**A-1, the next state is RUN
  - ready rises exactly 2**A cycles after Reset deasserts (16 cycles at A=4)
- State RUN: ready=1. RUN has no exit except Reset.
- During INIT:
  - lookup_en and wr_en are ignored; no table write from the port
  - target_valid stays 0 and target holds 0
- Lookup, latency 1:
  - lookup_en=1 at edge N in RUN → target and target_valid=1 are presented after edge N, for exactly one cycle
  - target holds its value after that cycle; target_valid returns to 0 unless another lookup occurs
  - back-to-back lookups are accepted every cycle
- Result arithmetic:
  - rel=0 → target = entry[addr]
  - rel=1 → target = (pc + entry[addr]) mod 2**D
  - this is a plain D-bit add with carry discarded; an entry of all ones acts as -1
- Write: wr_en=1 at edge N in RUN stores wr_data to entry[wr_addr] at edge N.
- Simultaneous write and lookup to different addresses: both proceed independently.
- Simultaneous write and lookup to the same address: the lookup returns the OLD entry value (read-before-write), unless the optional feature below is compiled in.
- Reset mid-INIT or mid-RUN:
  - outputs return to reset values immediately
  - INIT restarts from entry 0
  - any pending lookup result is discarded

Optional Feature:
- Macro: PC_LUT_BYPASS_EN
- Defined: a same-cycle write and lookup to the same address return wr_data, with the rel arithmetic applied to wr_data.
- Not defined: read-before-write, returning the old entry value.
- Both builds: a write is visible to any lookup issued on a later cycle.

Test Plan (all with D=10, A=4):
- Reset pulse, then idle → ready=0 for 16 cycles, then ready=1. Lookups of entries 0..15 each return target=0 with one valid pulse.
- Write entry1=11 and entry2=41. Then lookup addr=1 rel=0 and, next cycle, addr=2 rel=0 → target=11 then 41 on consecutive cycles, target_valid high for both cycles only.
- Write entry3=1023. Lookup addr=3 rel=1 pc=4 → target=3. Write entry4=20, lookup addr=4 rel=1 pc=1020 → target=16 (wrap).
- Entry5=87, then a same-cycle write of 72 to entry 5 plus lookup of entry 5 with rel=0:
  - without PC_LUT_BYPASS_EN → target=87
  - with PC_LUT_BYPASS_EN → target=72
  - a lookup on the next cycle → target=72 in both builds
- lookup_en and wr_en(entry6=99) during INIT → target_valid stays 0. After ready, lookup of entry 6 → target=0.
- Write entry7=97, assert Reset for 1 cycle in RUN with a lookup in flight → target=0 and target_valid=0 immediately, ready=0 for 16 cycles. Lookup of entry 7 afterwards → target=0.

Source files
------------

// File: rtl/pc_target_lut_rw.sv
// Run-time writable branch-target table with a registered lookup (absolute or PC-relative).
// Optional same-cycle write-to-lookup bypass when PC_LUT_BYPASS_EN is defined.
module pc_target_lut_rw #(
  parameter int D = 10,
  parameter int A = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         lookup_en,
  input  logic [A-1:0] addr,
  input  logic         rel,
  input  logic [D-1:0] pc,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  output logic         ready,
  output logic [D-1:0] target,
  output logic         target_valid
);

  localparam int N = 2 ** A;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t       state_q, state_d;
  logic [A-1:0] cnt_q, cnt_d;
  logic [D-1:0] target_q, target_d;
  logic         valid_q, valid_d;

  logic [D-1:0] mem_q [0:N-1];
  logic         mem_we;
  logic [A-1:0] mem_waddr;
  logic [D-1:0] mem_wdata;
  logic [D-1:0] rd_val;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    valid_d   = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    rd_val    = mem_q[addr];
`ifdef PC_LUT_BYPASS_EN
    if (wr_en && (wr_addr == addr)) rd_val = wr_data;
`endif
    case (state_q)
      ST_INIT: begin
        // The sequencer owns the write port until every entry is zeroed.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_we = wr_en;
        if (lookup_en) begin
          valid_d  = 1'b1;
          target_d = rel ? (pc + rd_val) : rd_val;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      target_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      valid_q  <= valid_d;
    end
  end

  // Table storage is not reset; INIT overwrites it before any lookup is accepted.
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ready        = (state_q == ST_RUN);
  assign target       = target_q;
  assign target_valid = valid_q;

endmodule

// File: tb/tb_pc_target_lut_rw.sv
// Self-checking bench for pc_target_lut_rw: directed test plan plus randomized traffic vs. an array model.
module tb_pc_target_lut_rw;

  localparam int D = 10;
  localparam int A = 4;
  localparam int N = 16;

  logic         Clk;
  logic         Reset;
  logic         lookup_en;
  logic [A-1:0] addr;
  logic         rel;
  logic [D-1:0] pc;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_data;
  logic         ready;
  logic [D-1:0] target;
  logic         target_valid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [D-1:0] model [N];
  logic [D-1:0] exp_t;
  logic         exp_v;

  pc_target_lut_rw #(.D(D), .A(A)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .lookup_en    (lookup_en),
    .addr         (addr),
    .rel          (rel),
    .pc           (pc),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .ready        (ready),
    .target       (target),
    .target_valid (target_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    lookup_en = 1'b0;
    addr      = '0;
    rel       = 1'b0;
    pc        = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
  endtask

  // Assert reset now, release it, then count the 16 INIT cycles (optionally poking the ports).
  task automatic do_reset(input bit poke);
    Reset = 1'b1;
    idle_inputs();
    #1;
    check("rst_ready", ready, 0);
    check("rst_target", target, 0);
    check("rst_valid", target_valid, 0);
    @(posedge Clk);
    #2;
    Reset = 1'b0;
    if (poke) begin
      lookup_en = 1'b1;
      addr      = 4'd6;
      wr_en     = 1'b1;
      wr_addr   = 4'd6;
      wr_data   = 10'd99;
    end
    for (int i = 0; i < N; i++) begin
      @(posedge Clk);
      #1;
      check("init_ready", ready, (i == N - 1) ? 1 : 0);
      check("init_valid", target_valid, 0);
      check("init_target", target, 0);
    end
    idle_inputs();
    for (int i = 0; i < N; i++) model[i] = '0;
    exp_t = '0;
    exp_v = 1'b0;
  endtask

  // One RUN cycle: drive inputs, predict from the model, clock, compare.
  task automatic step(input bit le, input logic [A-1:0] a, input bit r, input logic [D-1:0] p,
                      input bit we, input logic [A-1:0] wa, input logic [D-1:0] wd);
    logic [D-1:0] val;
    lookup_en = le;
    addr      = a;
    rel       = r;
    pc        = p;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    val = model[a];
`ifdef PC_LUT_BYPASS_EN
    if (we && (wa == a)) val = wd;
`endif
    exp_v = le;
    if (le) exp_t = r ? D'(p + val) : val;
    if (we) model[wa] = wd;
    @(posedge Clk);
    #1;
    check("run_valid", target_valid, exp_v);
    check("run_target", target, exp_t);
    check("run_ready", ready, 1);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    Reset = 1'b1;
    #3;
    do_reset(1'b0);

    for (int i = 0; i < N; i++) begin
      step(1'b1, A'(i), 1'b0, '0, 1'b0, '0, '0);
      check("clr_entry", target, 0);
    end

    step(1'b0, '0, 1'b0, '0, 1'b1, 4'd1, 10'd11);
    step(1'b0, '0, 1'b0, '0, 1'b1, 4'd2, 10'd41);
    step(1'b1, 4'd1, 1'b0, '0, 1'b0, '0, '0);
    check("e1_abs", target, 11);
    step(1'b1, 4'd2, 1'b0, '0, 1'b0, '0, '0);
    check("e2_abs", target, 41);
    check("e2_valid", target_valid, 1);
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    check("hold_target", target, 41);
    check("hold_valid", target_valid, 0);

    step(1'b0, '0, 1'b0, '0, 1'b1, 4'd3, 10'd1023);
    step(1'b1, 4'd3, 1'b1, 10'd4, 1'b0, '0, '0);
    check("rel_minus1", target, 3);
    step(1'b0, '0, 1'b0, '0, 1'b1, 4'd4, 10'd20);
    step(1'b1, 4'd4, 1'b1, 10'd1020, 1'b0, '0, '0);
    check("rel_wrap", target, 16);

    step(1'b0, '0, 1'b0, '0, 1'b1, 4'd5, 10'd87);
    step(1'b1, 4'd5, 1'b0, '0, 1'b1, 4'd5, 10'd72);
`ifdef PC_LUT_BYPASS_EN
    check("same_cycle", target, 72);
`else
    check("same_cycle", target, 87);
`endif
    step(1'b1, 4'd5, 1'b0, '0, 1'b0, '0, '0);
    check("next_cycle", target, 72);

    for (int k = 0; k < 400; k++) begin
      logic [A-1:0] a, wa;
      a  = A'($urandom_range(0, N - 1));
      wa = ($urandom_range(0, 3) == 0) ? a : A'($urandom_range(0, N - 1));
      step(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), D'($urandom),
           1'($urandom_range(0, 1)), wa, D'($urandom));
    end

    do_reset(1'b1);
    step(1'b1, 4'd6, 1'b0, '0, 1'b0, '0, '0);
    check("init_wr_ignored", target, 0);

    step(1'b0, '0, 1'b0, '0, 1'b1, 4'd7, 10'd97);
    step(1'b1, 4'd7, 1'b0, '0, 1'b0, '0, '0);
    check("e7_abs", target, 97);
    lookup_en = 1'b1;
    addr      = 4'd7;
    #2;
    do_reset(1'b0);
    step(1'b1, 4'd7, 1'b0, '0, 1'b0, '0, '0);
    check("e7_after_rst", target, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
